// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath (master) and hazard_ctrl (slave).
// stall_cnt exists only when HAZARD_PERF_EN is defined.
interface hazard_ctrl_if;
  logic [2:0]  rs_id;
  logic [2:0]  rt_id;
  logic        use_rs_id;
  logic        use_rt_id;
  logic        halt_id;
  logic        memread_ex;
  logic [2:0]  regwrite_adr_ex;
  logic        branch_taken_ex;
  logic        mem_req_mem;
  logic        mem_ready;
  logic        resume;
  logic        en_pc;
  logic        en_ifid;
  logic        en_idex;
  logic        en_exmem;
  logic        en_memwb;
  logic        flush_ifid;
  logic        flush_idex;
  logic        flush_exmem;
  logic        flush_memwb;
  logic        halted;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt;

  modport master (
    output rs_id, rt_id, use_rs_id, use_rt_id, halt_id, memread_ex,
           regwrite_adr_ex, branch_taken_ex, mem_req_mem, mem_ready, resume,
    input  en_pc, en_ifid, en_idex, en_exmem, en_memwb,
           flush_ifid, flush_idex, flush_exmem, flush_memwb, halted, stall_cnt
  );

  modport slave (
    input  rs_id, rt_id, use_rs_id, use_rt_id, halt_id, memread_ex,
           regwrite_adr_ex, branch_taken_ex, mem_req_mem, mem_ready, resume,
    output en_pc, en_ifid, en_idex, en_exmem, en_memwb,
           flush_ifid, flush_idex, flush_exmem, flush_memwb, halted, stall_cnt
  );
`else
  modport master (
    output rs_id, rt_id, use_rs_id, use_rt_id, halt_id, memread_ex,
           regwrite_adr_ex, branch_taken_ex, mem_req_mem, mem_ready, resume,
    input  en_pc, en_ifid, en_idex, en_exmem, en_memwb,
           flush_ifid, flush_idex, flush_exmem, flush_memwb, halted
  );

  modport slave (
    input  rs_id, rt_id, use_rs_id, use_rt_id, halt_id, memread_ex,
           regwrite_adr_ex, branch_taken_ex, mem_req_mem, mem_ready, resume,
    output en_pc, en_ifid, en_idex, en_exmem, en_memwb,
           flush_ifid, flush_idex, flush_exmem, flush_memwb, halted
  );
`endif
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use, taken branch, memory wait and HLT drain/halt.
// Optional stall-cycle counter enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

  state_t     state_q;
  logic [2:0] drain_cnt_q;

  logic       mstall;
  logic       lu;
  logic [1:0] src_hit;

  // One comparator per source operand; r0 is compared like any other register.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic [2:0] adr;
      logic       used;
      assign adr  = (gi == 0) ? bus.rs_id : bus.rt_id;
      assign used = (gi == 0) ? bus.use_rs_id : bus.use_rt_id;
      assign src_hit[gi] = used && (adr == bus.regwrite_adr_ex);
    end
  endgenerate

  assign mstall = bus.mem_req_mem && !bus.mem_ready;
  assign lu     = bus.memread_ex && (|src_hit);

  always_comb begin
    bus.en_pc       = 1'b1;
    bus.en_ifid     = 1'b1;
    bus.en_idex     = 1'b1;
    bus.en_exmem    = 1'b1;
    bus.en_memwb    = 1'b1;
    bus.flush_ifid  = 1'b0;
    bus.flush_idex  = 1'b0;
    bus.flush_exmem = 1'b0;
    bus.flush_memwb = 1'b0;
    bus.halted      = 1'b0;
    if (reset) begin
      bus.en_pc    = 1'b0;
      bus.en_ifid  = 1'b0;
      bus.en_idex  = 1'b0;
      bus.en_exmem = 1'b0;
      bus.en_memwb = 1'b0;
    end else begin
      case (state_q)
        RUN, DRAIN: begin
          if (mstall) begin
            // Hold everything up to EX/MEM and push a bubble into WB.
            bus.en_pc       = 1'b0;
            bus.en_ifid     = 1'b0;
            bus.en_idex     = 1'b0;
            bus.en_exmem    = 1'b0;
            bus.flush_memwb = 1'b1;
          end else if (state_q == RUN && bus.branch_taken_ex) begin
            bus.flush_ifid = 1'b1;
            bus.flush_idex = 1'b1;
          end else if (state_q == DRAIN || lu || bus.halt_id) begin
            bus.en_pc      = 1'b0;
            bus.en_ifid    = 1'b0;
            bus.flush_idex = 1'b1;
          end
        end
        HALT: begin
          bus.en_pc      = 1'b0;
          bus.en_ifid    = 1'b0;
          bus.en_idex    = 1'b0;
          bus.en_exmem   = 1'b0;
          bus.en_memwb   = 1'b0;
          bus.halted     = 1'b1;
          bus.flush_ifid = bus.resume;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      drain_cnt_q <= 3'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (!mstall && !bus.branch_taken_ex && !lu && bus.halt_id) begin
            state_q     <= DRAIN;
            drain_cnt_q <= 3'd0;
          end
        end
        DRAIN: begin
          if (!mstall) begin
            if (drain_cnt_q == DRAIN_LAST) begin
              state_q     <= HALT;
              drain_cnt_q <= 3'd0;
            end else begin
              drain_cnt_q <= drain_cnt_q + 3'd1;
            end
          end
        end
        HALT: begin
          if (bus.resume) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles in which the PC is held, HALT included.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
    end else if (!bus.en_pc && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed plus randomized bench for hazard_ctrl against a rule-level reference model.
module tb_hazard_ctrl;
  localparam int DC = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if intf ();
  hazard_ctrl #(.DRAIN_CYCLES(DC)) dut (.clk(clk), .reset(reset), .bus(intf));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode 0=run 1=drain 2=halt, drain progress in completed cycles.
  int ref_mode = 0;
  int ref_done = 0;
  int ref_stalls = 0;
  logic last_halted;

  function automatic logic [9:0] expect_out();
    logic ms, lu;
    ms = intf.mem_req_mem & ~intf.mem_ready;
    lu = intf.memread_ex & ((intf.use_rs_id & (intf.rs_id == intf.regwrite_adr_ex)) |
                            (intf.use_rt_id & (intf.rt_id == intf.regwrite_adr_ex)));
    // {en_pc,en_ifid,en_idex,en_exmem,en_memwb, fl_ifid,fl_idex,fl_exmem,fl_memwb, halted}
    if (reset) return 10'b00000_0000_0;
    if (ref_mode == 2) return intf.resume ? 10'b00000_1000_1 : 10'b00000_0000_1;
    if (ms) return 10'b00001_0001_0;
    if (ref_mode == 1) return 10'b00111_0100_0;
    if (intf.branch_taken_ex) return 10'b11111_1100_0;
    if (lu || intf.halt_id) return 10'b00111_0100_0;
    return 10'b11111_0000_0;
  endfunction

  task automatic model_step(input logic [9:0] e);
    logic ms, lu;
    ms = intf.mem_req_mem & ~intf.mem_ready;
    lu = intf.memread_ex & ((intf.use_rs_id & (intf.rs_id == intf.regwrite_adr_ex)) |
                            (intf.use_rt_id & (intf.rt_id == intf.regwrite_adr_ex)));
    if (reset) begin
      ref_mode = 0; ref_done = 0; ref_stalls = 0;
    end else begin
      if (!e[9] && ref_stalls < 65535) ref_stalls++;
      if (ref_mode == 0) begin
        if (!ms && !intf.branch_taken_ex && !lu && intf.halt_id) begin
          ref_mode = 1; ref_done = 0;
        end
      end else if (ref_mode == 1) begin
        if (!ms) begin
          ref_done++;
          if (ref_done == DC) ref_mode = 2;
        end
      end else if (intf.resume) begin
        ref_mode = 0;
      end
    end
  endtask

  task automatic do_cycle(input string tag);
    logic [9:0] e, o;
    #2;
    e = expect_out();
    o = {intf.en_pc, intf.en_ifid, intf.en_idex, intf.en_exmem, intf.en_memwb,
         intf.flush_ifid, intf.flush_idex, intf.flush_exmem, intf.flush_memwb, intf.halted};
    last_halted = intf.halted;
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s outputs obs=%b exp=%b", tag, o, e);
    end
`ifdef HAZARD_PERF_EN
    n_cmp++;
    assert (intf.stall_cnt === 16'(ref_stalls)) else begin
      n_bad++;
      $error("FAIL %s stall_cnt obs=%0d exp=%0d", tag, intf.stall_cnt, ref_stalls);
    end
`endif
    @(posedge clk);
    model_step(e);
    #1;
  endtask

  task automatic idle_inputs();
    intf.rs_id = 3'd0; intf.rt_id = 3'd0; intf.use_rs_id = 1'b0; intf.use_rt_id = 1'b0;
    intf.halt_id = 1'b0; intf.memread_ex = 1'b0; intf.regwrite_adr_ex = 3'd7;
    intf.branch_taken_ex = 1'b0; intf.mem_req_mem = 1'b0; intf.mem_ready = 1'b1;
    intf.resume = 1'b0;
  endtask

  task automatic run_to_halt(input string tag, input int n_ms, input int exp_cycle);
    int k;
    intf.halt_id = 1'b1;
    for (k = 0; k < 30; k++) begin
      intf.mem_req_mem = (k >= 2 && k < 2 + n_ms);
      intf.mem_ready   = 1'b0;
      do_cycle(tag);
      if (last_halted) break;
    end
    intf.mem_req_mem = 1'b0; intf.mem_ready = 1'b1; intf.halt_id = 1'b0;
    n_cmp++;
    assert (k === exp_cycle) else begin
      n_bad++;
      $error("FAIL %s halted_cycle obs=%0d exp=%0d", tag, k, exp_cycle);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #1;
    do_cycle("reset");
    do_cycle("reset2");
    reset = 1'b0;
    do_cycle("idle");

    // Load-use: LD r1 in EX, ADD reads r1 in ID.
    intf.memread_ex = 1'b1; intf.regwrite_adr_ex = 3'd1; intf.use_rs_id = 1'b1; intf.rs_id = 3'd1;
    do_cycle("loaduse");
    idle_inputs();
    do_cycle("loaduse_after");
    // Load-use through rt with r0.
    intf.memread_ex = 1'b1; intf.regwrite_adr_ex = 3'd0; intf.use_rt_id = 1'b1; intf.rt_id = 3'd0;
    do_cycle("loaduse_r0");
    intf.use_rt_id = 1'b0;
    do_cycle("no_use");
    idle_inputs();

    // Branch beats HLT.
    intf.branch_taken_ex = 1'b1; intf.halt_id = 1'b1;
    do_cycle("branch_hlt");
    idle_inputs();
    do_cycle("branch_after");

    // Memory wait for 4 cycles, coincident with a taken branch.
    for (int i = 0; i < 4; i++) begin
      intf.mem_req_mem = 1'b1; intf.mem_ready = 1'b0; intf.branch_taken_ex = 1'b1;
      do_cycle("mstall");
    end
    intf.mem_ready = 1'b1;
    do_cycle("mstall_release");
    idle_inputs();

    // HLT drain, then resume held for several cycles.
    run_to_halt("hlt_drain", 0, DC + 1);
    do_cycle("halt_hold");
    intf.resume = 1'b1;
    do_cycle("resume");
    do_cycle("resume_held");
    do_cycle("resume_held2");
    intf.resume = 1'b0;

    // HLT with two mstall cycles during DRAIN.
    run_to_halt("hlt_mstall", 2, DC + 3);

    // Reset while halted.
    reset = 1'b1;
    do_cycle("reset_halt");
    reset = 1'b0;
    do_cycle("after_reset");

    // Randomized traffic checked cycle by cycle.
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      intf.rs_id = 3'($urandom_range(0, 7));
      intf.rt_id = 3'($urandom_range(0, 7));
      intf.use_rs_id = 1'($urandom_range(0, 1));
      intf.use_rt_id = 1'($urandom_range(0, 1));
      intf.halt_id = ($urandom_range(0, 11) == 0);
      intf.memread_ex = ($urandom_range(0, 2) == 0);
      intf.regwrite_adr_ex = 3'($urandom_range(0, 7));
      intf.branch_taken_ex = ($urandom_range(0, 7) == 0);
      intf.mem_req_mem = 1'($urandom_range(0, 1));
      intf.mem_ready = 1'($urandom_range(0, 1));
      intf.resume = ($urandom_range(0, 3) == 0);
      do_cycle("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
